// File: rtl/register_file_scoreboard.sv
// Two-read/one-write register file with a per-register pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward the writeback value and clear busy in the same cycle.
module register_file_scoreboard #(
   parameter int WIDTH = 8,
   parameter int NREGS = 32,
   parameter int AW    = $clog2(NREGS),
   parameter int CW    = $clog2(NREGS) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             regwrite,
   input  logic [AW-1:0]    wa,
   input  logic [WIDTH-1:0] wd,
   input  logic [AW-1:0]    ra1,
   input  logic [AW-1:0]    ra2,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2,
   input  logic             issue,
   input  logic [AW-1:0]    issue_addr,
   output logic             busy1,
   output logic             busy2,
   output logic [CW-1:0]    pend_cnt,
   output logic             waw
);

   logic [WIDTH-1:0] regs_q [1:NREGS-1];
   logic [WIDTH-1:0] regs_d [1:NREGS-1];
   logic [NREGS-1:0] pend_q, pend_d;
   logic [CW-1:0]    pend_cnt_q, pend_cnt_d;
   logic             waw_q, waw_d;
   logic             wr_en, iss_en, same_reg, inc, dec;
   logic             hit1, hit2;

   // Reset also gates the forwarding path so outputs read 0 while reset is held.
   assign wr_en    = regwrite && (wa != '0) && !reset;
   assign iss_en   = issue && (issue_addr != '0);
   assign same_reg = wr_en && iss_en && (wa == issue_addr);

`ifdef REGFILE_BYPASS_EN
   assign hit1 = wr_en && (wa == ra1);
   assign hit2 = wr_en && (wa == ra2);
`else
   assign hit1 = 1'b0;
   assign hit2 = 1'b0;
`endif

   always_comb begin
      for (int i = 1; i < NREGS; i++) begin
         regs_d[i] = (wr_en && (wa == AW'(i))) ? wd : regs_q[i];
      end
   end

   // Issue is applied after writeback so a new producer wins over a retiring one.
   always_comb begin
      pend_d = pend_q;
      if (wr_en)  pend_d[wa] = 1'b0;
      if (iss_en) pend_d[issue_addr] = 1'b1;
      pend_d[0] = 1'b0;
   end

   always_comb begin
      inc        = iss_en && !pend_q[issue_addr];
      dec        = wr_en && pend_q[wa] && !same_reg;
      pend_cnt_d = pend_cnt_q + {{(CW-1){1'b0}}, inc} - {{(CW-1){1'b0}}, dec};
      waw_d      = iss_en && pend_q[issue_addr] && !same_reg;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 1; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
         pend_q     <= '0;
         pend_cnt_q <= '0;
         waw_q      <= 1'b0;
      end else begin
         for (int i = 1; i < NREGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
         pend_q     <= pend_d;
         pend_cnt_q <= pend_cnt_d;
         waw_q      <= waw_d;
      end
   end

   always_comb begin
      rd1 = '0;
      if (hit1)              rd1 = wd;
      else if (ra1 != '0)    rd1 = regs_q[ra1];
      rd2 = '0;
      if (hit2)              rd2 = wd;
      else if (ra2 != '0)    rd2 = regs_q[ra2];
   end

   assign busy1    = (ra1 != '0) && pend_q[ra1] && !hit1;
   assign busy2    = (ra2 != '0) && pend_q[ra2] && !hit2;
   assign pend_cnt = pend_cnt_q;
   assign waw      = waw_q;

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Self-checking bench for register_file_scoreboard: vector table, directed corners, randomized model check.
module tb_register_file_scoreboard;
   localparam int W  = 8;
   localparam int N  = 32;
   localparam int AW = 5;
   localparam int CW = 6;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset, regwrite, issue;
   logic [AW-1:0] wa, ra1, ra2, issue_addr;
   logic [W-1:0]  wd, rd1, rd2;
   logic          busy1, busy2, waw;
   logic [CW-1:0] pend_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   register_file_scoreboard #(.WIDTH(W), .NREGS(N)) dut (
      .clk(clk), .reset(reset), .regwrite(regwrite), .wa(wa), .wd(wd),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .issue(issue),
      .issue_addr(issue_addr), .busy1(busy1), .busy2(busy2),
      .pend_cnt(pend_cnt), .waw(waw)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rw;
      logic [AW-1:0] wa;
      logic [W-1:0]  wd;
      logic [AW-1:0] ra1;
      logic [AW-1:0] ra2;
      logic          iss;
      logic [AW-1:0] ia;
      logic [W-1:0]  e_rd1;
      logic [W-1:0]  e_rd2;
      logic          e_b1;
      logic          e_b2;
      logic [CW-1:0] e_cnt;
      logic          e_waw;
   } vec_t;

   vec_t tbl [15];

   logic [W-1:0] mreg  [N];
   bit           mpend [N];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic i_rw, input logic [AW-1:0] i_wa, input logic [W-1:0] i_wd,
                        input logic [AW-1:0] i_ra1, input logic [AW-1:0] i_ra2,
                        input logic i_is, input logic [AW-1:0] i_ia);
      regwrite   = i_rw;
      wa         = i_wa;
      wd         = i_wd;
      ra1        = i_ra1;
      ra2        = i_ra2;
      issue      = i_is;
      issue_addr = i_ia;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, N-1)) : AW'($urandom_range(0, 7));
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // rw wa wd ra1 ra2 iss ia | rd1 rd2 b1 b2 cnt waw
      tbl[0]  = '{1'b1, 5'd1, 8'hAA, 5'd0, 5'd0, 1'b0, 5'd0, 8'h00, 8'h00, 1'b0, 1'b0, 6'd0, 1'b0};
      tbl[1]  = '{1'b1, 5'd2, 8'h55, 5'd1, 5'd0, 1'b0, 5'd0, 8'hAA, 8'h00, 1'b0, 1'b0, 6'd0, 1'b0};
      tbl[2]  = '{1'b1, 5'd0, 8'hFF, 5'd1, 5'd2, 1'b0, 5'd0, 8'hAA, 8'h55, 1'b0, 1'b0, 6'd0, 1'b0};
      tbl[3]  = '{1'b0, 5'd0, 8'h00, 5'd0, 5'd0, 1'b0, 5'd0, 8'h00, 8'h00, 1'b0, 1'b0, 6'd0, 1'b0};
      tbl[4]  = '{1'b0, 5'd0, 8'h00, 5'd3, 5'd1, 1'b1, 5'd3, 8'h00, 8'hAA, 1'b0, 1'b0, 6'd1, 1'b0};
      tbl[5]  = '{1'b0, 5'd0, 8'h00, 5'd3, 5'd0, 1'b0, 5'd0, 8'h00, 8'h00, 1'b1, 1'b0, 6'd1, 1'b0};
      tbl[6]  = '{1'b1, 5'd3, 8'h11, 5'd1, 5'd2, 1'b0, 5'd0, 8'hAA, 8'h55, 1'b0, 1'b0, 6'd0, 1'b0};
      tbl[7]  = '{1'b0, 5'd0, 8'h00, 5'd3, 5'd0, 1'b0, 5'd0, 8'h11, 8'h00, 1'b0, 1'b0, 6'd0, 1'b0};
      tbl[8]  = '{1'b0, 5'd0, 8'h00, 5'd4, 5'd0, 1'b1, 5'd4, 8'h00, 8'h00, 1'b0, 1'b0, 6'd1, 1'b0};
      tbl[9]  = '{1'b0, 5'd0, 8'h00, 5'd4, 5'd3, 1'b1, 5'd4, 8'h00, 8'h11, 1'b1, 1'b0, 6'd1, 1'b1};
      tbl[10] = '{1'b0, 5'd0, 8'h00, 5'd4, 5'd0, 1'b0, 5'd0, 8'h00, 8'h00, 1'b1, 1'b0, 6'd1, 1'b0};
      tbl[11] = '{1'b1, 5'd4, 8'h77, 5'd1, 5'd2, 1'b1, 5'd4, 8'hAA, 8'h55, 1'b0, 1'b0, 6'd1, 1'b0};
      tbl[12] = '{1'b0, 5'd0, 8'h00, 5'd4, 5'd0, 1'b0, 5'd0, 8'h77, 8'h00, 1'b1, 1'b0, 6'd1, 1'b0};
      tbl[13] = '{1'b1, 5'd4, 8'h22, 5'd0, 5'd2, 1'b0, 5'd0, 8'h00, 8'h55, 1'b0, 1'b0, 6'd0, 1'b0};
      tbl[14] = '{1'b0, 5'd0, 8'h00, 5'd0, 5'd0, 1'b1, 5'd0, 8'h00, 8'h00, 1'b0, 1'b0, 6'd0, 1'b0};

      // Power-on reset
      reset = 1'b1;
      drive(0, 0, 0, 1, 2, 0, 0);
      tick();
      tick();
      chk("reset_rd1", rd1, 0);
      chk("reset_rd2", rd2, 0);
      chk("reset_busy1", busy1, 0);
      chk("reset_cnt", pend_cnt, 0);
      chk("reset_waw", waw, 0);
      reset = 1'b0;
      $display("reset released");

      // Table vectors: combinational outputs before the edge, registered after
      for (int v = 0; v < 15; v++) begin
         drive(tbl[v].rw, tbl[v].wa, tbl[v].wd, tbl[v].ra1, tbl[v].ra2, tbl[v].iss, tbl[v].ia);
         chk($sformatf("vec%0d_rd1", v), rd1, tbl[v].e_rd1);
         chk($sformatf("vec%0d_rd2", v), rd2, tbl[v].e_rd2);
         chk($sformatf("vec%0d_busy1", v), busy1, tbl[v].e_b1);
         chk($sformatf("vec%0d_busy2", v), busy2, tbl[v].e_b2);
         tick();
         chk($sformatf("vec%0d_cnt", v), pend_cnt, tbl[v].e_cnt);
         chk($sformatf("vec%0d_waw", v), waw, tbl[v].e_waw);
         $display("vec %0d: rw=%0d wa=%0d wd=%02h ra=%0d/%0d iss=%0d ia=%0d -> rd=%02h/%02h busy=%0d%0d cnt=%0d waw=%0d",
                  v, tbl[v].rw, tbl[v].wa, tbl[v].wd, tbl[v].ra1, tbl[v].ra2, tbl[v].iss, tbl[v].ia,
                  rd1, rd2, busy1, busy2, pend_cnt, waw);
      end

      // Same-cycle writeback to a register being read
      drive(1, 5, 8'h99, 0, 0, 1, 5);
      tick();
      chk("byp_setwin_cnt", pend_cnt, 1);
      drive(1, 5, 8'h3C, 5, 0, 0, 0);
      chk("byp_rd1", rd1, BYP ? 8'h3C : 8'h99);
      chk("byp_busy1", busy1, BYP ? 0 : 1);
      tick();
      chk("byp_cnt", pend_cnt, 0);
      drive(0, 0, 0, 5, 0, 0, 0);
      chk("byp_after_rd1", rd1, 8'h3C);
      chk("byp_after_busy1", busy1, 0);
      $display("bypass seq: rd1=%02h busy1=%0d", rd1, busy1);

      // Claim every register, then r0
      for (int i = 1; i < N; i++) begin
         drive(0, 0, 0, 0, 0, 1, AW'(i));
         tick();
         chk($sformatf("fill%0d_cnt", i), pend_cnt, i);
         chk($sformatf("fill%0d_waw", i), waw, 0);
      end
      $display("fill: cnt=%0d", pend_cnt);
      drive(0, 0, 0, 0, 0, 1, 0);
      chk("r0_busy1", busy1, 0);
      tick();
      chk("r0_cnt", pend_cnt, N-1);
      chk("r0_waw", waw, 0);
      drive(0, 0, 0, 0, 0, 1, 1);
      tick();
      chk("full_waw", waw, 1);
      chk("full_cnt", pend_cnt, N-1);

      // Mid-cycle async reset with write and issue active
      drive(1, 2, 8'hEE, 1, 2, 1, 3);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_rd1", rd1, 0);
      chk("midrst_rd2", rd2, 0);
      chk("midrst_busy1", busy1, 0);
      chk("midrst_busy2", busy2, 0);
      chk("midrst_cnt", pend_cnt, 0);
      chk("midrst_waw", waw, 0);
      tick();
      reset = 1'b0;
      drive(0, 0, 0, 1, 2, 0, 0);
      chk("postrst_rd1", rd1, 0);
      chk("postrst_rd2", rd2, 0);
      tick();
      chk("postrst_cnt", pend_cnt, 0);
      $display("mid-run reset: rd=%02h/%02h cnt=%0d waw=%0d", rd1, rd2, pend_cnt, waw);

      // Randomized run against reference model (starts from cleared state)
      for (int i = 0; i < N; i++) begin
         mreg[i]  = '0;
         mpend[i] = 1'b0;
      end
      for (int c = 0; c < 500; c++) begin
         logic          r_rw, r_is, e_b1, e_b2, e_waw;
         logic [AW-1:0] r_wa, r_ra1, r_ra2, r_ia;
         logic [W-1:0]  r_wd, e_rd1, e_rd2;
         int            e_cnt;
         r_rw  = 1'($urandom_range(0, 1));
         r_is  = 1'($urandom_range(0, 1));
         r_wa  = rnd_addr();
         r_ia  = rnd_addr();
         r_ra1 = rnd_addr();
         r_ra2 = rnd_addr();
         r_wd  = W'($urandom);
         e_rd1 = (r_ra1 == 0) ? '0 : (BYP && r_rw && r_wa == r_ra1) ? r_wd : mreg[r_ra1];
         e_rd2 = (r_ra2 == 0) ? '0 : (BYP && r_rw && r_wa == r_ra2) ? r_wd : mreg[r_ra2];
         e_b1  = (r_ra1 != 0) && mpend[r_ra1] && !(BYP && r_rw && r_wa == r_ra1);
         e_b2  = (r_ra2 != 0) && mpend[r_ra2] && !(BYP && r_rw && r_wa == r_ra2);
         drive(r_rw, r_wa, r_wd, r_ra1, r_ra2, r_is, r_ia);
         chk("rnd_rd1", rd1, e_rd1);
         chk("rnd_rd2", rd2, e_rd2);
         chk("rnd_busy1", busy1, e_b1);
         chk("rnd_busy2", busy2, e_b2);
         e_waw = r_is && (r_ia != 0) && mpend[r_ia] && !(r_rw && r_wa == r_ia);
         if (r_rw && r_wa != 0) begin
            mreg[r_wa]  = r_wd;
            mpend[r_wa] = 1'b0;
         end
         if (r_is && r_ia != 0) mpend[r_ia] = 1'b1;
         e_cnt = 0;
         for (int k = 0; k < N; k++) e_cnt += int'(mpend[k]);
         tick();
         chk("rnd_cnt", pend_cnt, e_cnt);
         chk("rnd_waw", waw, e_waw);
         $display("rnd %0d: rw=%0d wa=%0d iss=%0d ia=%0d ra=%0d/%0d -> rd=%02h/%02h cnt=%0d waw=%0d",
                  c, r_rw, r_wa, r_is, r_ia, r_ra1, r_ra2, e_rd1, e_rd2, pend_cnt, waw);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
